seg7_message_sequencer: RTL and testbench

Plays a stored message of glyph codes on the single 7-segment display, one glyph at a time. Each glyph is held for a programmable dwell, followed by an optional blank gap so that repeated glyphs stay distinguishable. It sits between the switch/control logic (message loading, start/stop) and the `SEG` output. It owns the display while playing and drives blank when idle.

---
 rtl/seg7_pkg.sv | 63 ++++++
 rtl/seg7_glyph_rom.sv | 60 ++++++
 rtl/seg7_message_sequencer.sv | 179 +++++++++++++++++
 tb/tb_seg7_message_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph codes, segment patterns and sequencer state type.
// Segment vectors are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  typedef logic [5:0] glyph_code_t;
  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_DASH  = 7'b1000000;

  // hex digits, codes 0..15
  localparam seg_t SEG_HEX_0 = 7'b0111111;
  localparam seg_t SEG_HEX_1 = 7'b0000110;
  localparam seg_t SEG_HEX_2 = 7'b1011011;
  localparam seg_t SEG_HEX_3 = 7'b1001111;
  localparam seg_t SEG_HEX_4 = 7'b1100110;
  localparam seg_t SEG_HEX_5 = 7'b1101101;
  localparam seg_t SEG_HEX_6 = 7'b1111101;
  localparam seg_t SEG_HEX_7 = 7'b0000111;
  localparam seg_t SEG_HEX_8 = 7'b1111111;
  localparam seg_t SEG_HEX_9 = 7'b1101111;
  localparam seg_t SEG_HEX_A = 7'b1110111;
  localparam seg_t SEG_HEX_B = 7'b1111100;
  localparam seg_t SEG_HEX_C = 7'b0111001;
  localparam seg_t SEG_HEX_D = 7'b1011110;
  localparam seg_t SEG_HEX_E = 7'b1111001;
  localparam seg_t SEG_HEX_F = 7'b1110001;

  // letters, codes 16 (A) .. 41 (Z); some letters only approximate on 7 segments
  localparam seg_t SEG_LTR_A = 7'b1110111;
  localparam seg_t SEG_LTR_B = 7'b1111100;
  localparam seg_t SEG_LTR_C = 7'b0111001;
  localparam seg_t SEG_LTR_D = 7'b1011110;
  localparam seg_t SEG_LTR_E = 7'b1111001;
  localparam seg_t SEG_LTR_F = 7'b1110001;
  localparam seg_t SEG_LTR_G = 7'b0111101;
  localparam seg_t SEG_LTR_H = 7'b1110110;
  localparam seg_t SEG_LTR_I = 7'b0110000;
  localparam seg_t SEG_LTR_J = 7'b0011110;
  localparam seg_t SEG_LTR_K = 7'b1110101;
  localparam seg_t SEG_LTR_L = 7'b0111000;
  localparam seg_t SEG_LTR_M = 7'b0110111;
  localparam seg_t SEG_LTR_N = 7'b1010100;
  localparam seg_t SEG_LTR_O = 7'b0111111;
  localparam seg_t SEG_LTR_P = 7'b1110011;
  localparam seg_t SEG_LTR_Q = 7'b1100111;
  localparam seg_t SEG_LTR_R = 7'b1110011;
  localparam seg_t SEG_LTR_S = 7'b1101101;
  localparam seg_t SEG_LTR_T = 7'b1111000;
  localparam seg_t SEG_LTR_U = 7'b0111110;
  localparam seg_t SEG_LTR_V = 7'b0011100;
  localparam seg_t SEG_LTR_W = 7'b0101010;
  localparam seg_t SEG_LTR_X = 7'b1110110;
  localparam seg_t SEG_LTR_Y = 7'b1101110;
  localparam seg_t SEG_LTR_Z = 7'b1011011;

endpackage

// File: rtl/seg7_glyph_rom.sv
// seg7_glyph_rom: glyph code to segment pattern lookup, shared by display blocks.
// Codes outside the table show a dash.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  glyph_code_t code,
  output seg_t        seg
);

  // full team glyph table
  always_comb begin
    seg = SEG_DASH;
    case (code)
      6'd0:    seg = SEG_HEX_0;
      6'd1:    seg = SEG_HEX_1;
      6'd2:    seg = SEG_HEX_2;
      6'd3:    seg = SEG_HEX_3;
      6'd4:    seg = SEG_HEX_4;
      6'd5:    seg = SEG_HEX_5;
      6'd6:    seg = SEG_HEX_6;
      6'd7:    seg = SEG_HEX_7;
      6'd8:    seg = SEG_HEX_8;
      6'd9:    seg = SEG_HEX_9;
      6'd10:   seg = SEG_HEX_A;
      6'd11:   seg = SEG_HEX_B;
      6'd12:   seg = SEG_HEX_C;
      6'd13:   seg = SEG_HEX_D;
      6'd14:   seg = SEG_HEX_E;
      6'd15:   seg = SEG_HEX_F;
      6'd16:   seg = SEG_LTR_A;
      6'd17:   seg = SEG_LTR_B;
      6'd18:   seg = SEG_LTR_C;
      6'd19:   seg = SEG_LTR_D;
      6'd20:   seg = SEG_LTR_E;
      6'd21:   seg = SEG_LTR_F;
      6'd22:   seg = SEG_LTR_G;
      6'd23:   seg = SEG_LTR_H;
      6'd24:   seg = SEG_LTR_I;
      6'd25:   seg = SEG_LTR_J;
      6'd26:   seg = SEG_LTR_K;
      6'd27:   seg = SEG_LTR_L;
      6'd28:   seg = SEG_LTR_M;
      6'd29:   seg = SEG_LTR_N;
      6'd30:   seg = SEG_LTR_O;
      6'd31:   seg = SEG_LTR_P;
      6'd32:   seg = SEG_LTR_Q;
      6'd33:   seg = SEG_LTR_R;
      6'd34:   seg = SEG_LTR_S;
      6'd35:   seg = SEG_LTR_T;
      6'd36:   seg = SEG_LTR_U;
      6'd37:   seg = SEG_LTR_V;
      6'd38:   seg = SEG_LTR_W;
      6'd39:   seg = SEG_LTR_X;
      6'd40:   seg = SEG_LTR_Y;
      6'd41:   seg = SEG_LTR_Z;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_message_sequencer.sv
// seg7_message_sequencer: plays a buffered glyph message on one 7-segment digit,
// each glyph held HOLD_CYCLES then blanked GAP_CYCLES.
// Build option SEG7_SEQ_LOOP_EN: wrap and replay while play stays high.
// Without it: one pass, then idle until play is dropped and raised again.
//
// state | meaning
// IDLE  | display blank, buffer writable
// SHOW  | glyph of entry index on seg, dwell timer running
// GAP   | blank between glyphs, gap timer running
module seg7_message_sequencer
  import seg7_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                     clk_2,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     wr_valid,
  input  logic [5:0]               wr_code,
  output logic                     wr_ready,
  input  logic                     play,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] index,
  output logic [7:0]               seg
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(HOLD_CYCLES + GAP_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW:0]   FULL      = (IW + 1)'(DEPTH);

  seq_state_t    state, state_nxt;
  logic [IW-1:0] index_nxt;
  logic [CW-1:0] tmr, tmr_nxt;
  logic          done_nxt;
  logic          advance;
  logic          start_ok;
  logic          is_last;
  logic          dp_nxt;
  logic [IW:0]   last_idx;
  glyph_code_t   msg_mem [DEPTH];
  seg_t          glyph;
  logic [7:0]    seg_nxt;

  assign wr_ready = (state == IDLE) && (count != FULL) && !play && !clear;
  assign last_idx = count - 1'b1;
  assign is_last  = ({1'b0, index} == last_idx);

`ifdef SEG7_SEQ_LOOP_EN
  assign start_ok = play && (count != '0);
`else
  logic pass_latched;

  // a finished pass blocks restart until play has been seen low
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n)        pass_latched <= 1'b0;
    else if (!play)    pass_latched <= 1'b0;
    else if (done_nxt) pass_latched <= 1'b1;
  end

  assign start_ok = play && (count != '0) && !pass_latched;
`endif

  // message buffer; contents are not reset, count alone says what is valid
  always_ff @(posedge clk_2) begin
    if (wr_valid && wr_ready) msg_mem[count[IW-1:0]] <= wr_code;
  end

  // state, timer and registered outputs
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      index <= '0;
      tmr   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      seg   <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
      tmr   <= tmr_nxt;
      done  <= done_nxt;
      busy  <= (state_nxt != IDLE);
      seg   <= seg_nxt;
      if (clear)                      count <= '0;
      else if (wr_valid && wr_ready)  count <= count + 1'b1;
    end
  end

  // next state: clear beats play, play low aborts, timers count down to zero
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    tmr_nxt   = tmr;
    done_nxt  = 1'b0;
    advance   = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      index_nxt = '0;
      tmr_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state_nxt = SHOW;
            index_nxt = '0;
            tmr_nxt   = HOLD_LOAD;
          end
        end
        SHOW: begin
          if (!play) begin
            state_nxt = IDLE;
            index_nxt = '0;
            tmr_nxt   = '0;
          end else if (tmr != '0) begin
            tmr_nxt = tmr - 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
            tmr_nxt   = GAP_LOAD;
          end else begin
            advance = 1'b1;
          end
        end
        GAP: begin
          if (!play) begin
            state_nxt = IDLE;
            index_nxt = '0;
            tmr_nxt   = '0;
          end else if (tmr != '0) begin
            tmr_nxt = tmr - 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          index_nxt = '0;
          tmr_nxt   = '0;
        end
      endcase
      if (advance) begin
        if (!is_last) begin
          state_nxt = SHOW;
          index_nxt = index + 1'b1;
          tmr_nxt   = HOLD_LOAD;
        end else begin
          done_nxt  = 1'b1;
          index_nxt = '0;
`ifdef SEG7_SEQ_LOOP_EN
          state_nxt = SHOW;
          tmr_nxt   = HOLD_LOAD;
`else
          state_nxt = IDLE;
          tmr_nxt   = '0;
`endif
        end
      end
    end
  end

  seg7_glyph_rom u_glyph_rom (
    .code (msg_mem[index_nxt]),
    .seg  (glyph)
  );

  // seg is registered from the next entry so the glyph appears one edge after play is seen
  always_comb begin
    dp_nxt  = ({1'b0, index_nxt} == last_idx);
    seg_nxt = 8'h00;
    if (state_nxt == SHOW) seg_nxt = {dp_nxt, glyph};
  end

endmodule

// File: tb/tb_seg7_message_sequencer.sv
// tb_seg7_message_sequencer: random message playback checked against a
// timeline model of the display (glyph, dp, done, busy, index per cycle).
module tb_seg7_message_sequencer;

  localparam int H = 4;

  localparam logic [6:0] GLYPHS [42] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
    7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76,
    7'h30, 7'h1E, 7'h75, 7'h38, 7'h37, 7'h54, 7'h3F, 7'h73,
    7'h67, 7'h73, 7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h2A, 7'h76,
    7'h6E, 7'h5B
  };

  logic       clk_2 = 1'b0;
  logic       rst_n;
  logic       clear, wr_valid, play;
  logic [5:0] wr_code;
  logic       wr_ready, busy, done;
  logic [3:0] count;
  logic [2:0] index;
  logic [7:0] seg;

  logic       g_clear, g_wr_valid, g_play;
  logic [5:0] g_wr_code;
  logic       g_wr_ready, g_busy, g_done;
  logic [3:0] g_count;
  logic [2:0] g_index;
  logic [7:0] g_seg;

  int errors = 0;
  int checks = 0;
  logic [5:0] mdl_codes [9];

  always #5 clk_2 = ~clk_2;

  seg7_message_sequencer dut (
    .clk_2(clk_2), .rst_n(rst_n), .clear(clear), .wr_valid(wr_valid),
    .wr_code(wr_code), .wr_ready(wr_ready), .play(play), .busy(busy),
    .done(done), .count(count), .index(index), .seg(seg)
  );

  seg7_message_sequencer #(.GAP_CYCLES(0)) dut_g0 (
    .clk_2(clk_2), .rst_n(rst_n), .clear(g_clear), .wr_valid(g_wr_valid),
    .wr_code(g_wr_code), .wr_ready(g_wr_ready), .play(g_play), .busy(g_busy),
    .done(g_done), .count(g_count), .index(g_index), .seg(g_seg)
  );

  function automatic logic [6:0] ref_glyph(input logic [5:0] code);
    if (code < 6'd42) return GLYPHS[code];
    return 7'b1000000;
  endfunction

  // c = cycles since the edge that first sampled play high
  function automatic int pass_len(input int n, input int g);
    return n * (H + g);
  endfunction

  function automatic logic [7:0] exp_seg(input int c, input int n, input int g);
    int p;
    int pos;
    int k;
    p = H + g;
`ifdef SEG7_SEQ_LOOP_EN
    pos = c % pass_len(n, g);
`else
    if (c >= pass_len(n, g)) return 8'h00;
    pos = c;
`endif
    k = pos / p;
    if ((pos % p) >= H) return 8'h00;
    return {(k == n - 1), ref_glyph(mdl_codes[k])};
  endfunction

  function automatic logic exp_done(input int c, input int n, input int g);
`ifdef SEG7_SEQ_LOOP_EN
    return (c > 0) && (c % pass_len(n, g) == 0);
`else
    return c == pass_len(n, g);
`endif
  endfunction

  function automatic logic exp_busy(input int c, input int n, input int g);
`ifdef SEG7_SEQ_LOOP_EN
    return 1'b1;
`else
    return c < pass_len(n, g);
`endif
  endfunction

  function automatic logic [2:0] exp_index(input int c, input int n, input int g);
`ifdef SEG7_SEQ_LOOP_EN
    return 3'((c % pass_len(n, g)) / (H + g));
`else
    if (c >= pass_len(n, g)) return 3'd0;
    return 3'(c / (H + g));
`endif
  endfunction

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic write_codes(input int n);
    for (int k = 0; k < n; k++) begin
      wr_valid = 1'b1;
      wr_code  = mdl_codes[k];
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (seg !== 8'h00)   begin errors++; $display("FAIL reset_seg got %h want 00", seg); end
    checks++; if (count !== 4'd0)  begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (index !== 3'd0)  begin errors++; $display("FAIL reset_index got %0d want 0", index); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    @(negedge clk_2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    mdl_codes[0] = 6'd1; mdl_codes[1] = 6'd10; mdl_codes[2] = 6'd33;
    do_clear();
    write_codes(3);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count got %0d want 3", count); end
    play = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (seg !== exp_seg(c, 3, 1)) begin errors++; $display("FAIL basic_seg c=%0d got %h want %h", c, seg, exp_seg(c, 3, 1)); end
      checks++; if (done !== exp_done(c, 3, 1)) begin errors++; $display("FAIL basic_done c=%0d got %b want %b", c, done, exp_done(c, 3, 1)); end
      checks++; if (index !== exp_index(c, 3, 1)) begin errors++; $display("FAIL basic_index c=%0d got %0d want %0d", c, index, exp_index(c, 3, 1)); end
      checks++; if (busy !== exp_busy(c, 3, 1)) begin errors++; $display("FAIL basic_busy c=%0d got %b want %b", c, busy, exp_busy(c, 3, 1)); end
    end
    play = 1'b0;
    tick();
    checks++; if (seg !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL basic_stop seg=%h busy=%b want 00/0", seg, busy); end
  endtask

  task automatic test_full();
    do_clear();
    for (int k = 0; k < 9; k++) mdl_codes[k] = 6'($urandom_range(0, 63));
    for (int k = 0; k < 9; k++) begin
      wr_valid = 1'b1;
      wr_code  = mdl_codes[k];
      #1;
      checks++; if (wr_ready !== (k < 8)) begin errors++; $display("FAIL full_wr_ready k=%0d got %b want %b", k, wr_ready, (k < 8)); end
      tick();
      checks++; if (count !== 4'((k < 8) ? k + 1 : 8)) begin errors++; $display("FAIL full_count k=%0d got %0d want %0d", k, count, (k < 8) ? k + 1 : 8); end
    end
    wr_valid = 1'b0;
    play = 1'b1;
    for (int c = 0; c < 2 * pass_len(8, 1) + 2; c++) begin
      tick();
      checks++; if (seg !== exp_seg(c, 8, 1)) begin errors++; $display("FAIL full_seg c=%0d got %h want %h", c, seg, exp_seg(c, 8, 1)); end
      checks++; if (done !== exp_done(c, 8, 1)) begin errors++; $display("FAIL full_done c=%0d got %b want %b", c, done, exp_done(c, 8, 1)); end
    end
    play = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int n;
    int stop;
    n = $urandom_range(3, 8);
    for (int k = 0; k < n; k++) mdl_codes[k] = 6'($urandom_range(0, 63));
    do_clear();
    write_codes(n);
    stop = 2 * (H + 1) + $urandom_range(0, H - 1);
    play = 1'b1;
    for (int c = 0; c <= stop; c++) begin
      tick();
      checks++; if (seg !== exp_seg(c, n, 1)) begin errors++; $display("FAIL abort_pre_seg c=%0d got %h want %h", c, seg, exp_seg(c, n, 1)); end
    end
    play = 1'b0;
    tick();
    checks++; if (seg !== 8'h00)  begin errors++; $display("FAIL abort_seg got %h want 00", seg); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (index !== 3'd0) begin errors++; $display("FAIL abort_index got %0d want 0", index); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL abort_done got %b want 0", done); end
    play = 1'b1;
    for (int c = 0; c < pass_len(n, 1) + 3; c++) begin
      tick();
      checks++; if (seg !== exp_seg(c, n, 1)) begin errors++; $display("FAIL abort_restart_seg c=%0d got %h want %h", c, seg, exp_seg(c, n, 1)); end
      checks++; if (done !== exp_done(c, n, 1)) begin errors++; $display("FAIL abort_restart_done c=%0d got %b want %b", c, done, exp_done(c, n, 1)); end
    end
    play = 1'b0;
    tick();
  endtask

  task automatic test_clear_priority();
    mdl_codes[0] = 6'd7; mdl_codes[1] = 6'd20;
    do_clear();
    write_codes(2);
    play = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    clear = 1'b1; wr_valid = 1'b1; wr_code = 6'd5;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clrpri_wr_ready got %b want 0", wr_ready); end
    tick();
    checks++; if (count !== 4'd0)  begin errors++; $display("FAIL clrpri_count got %0d want 0", count); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL clrpri_busy got %b want 0", busy); end
    checks++; if (seg !== 8'h00)   begin errors++; $display("FAIL clrpri_seg got %h want 00", seg); end
    checks++; if (index !== 3'd0)  begin errors++; $display("FAIL clrpri_index got %0d want 0", index); end
    clear = 1'b0; wr_valid = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL clrpri_empty_play busy=%b count=%0d want 0/0", busy, count); end
    play = 1'b0;
    tick();
  endtask

  task automatic test_random_messages();
    int n;
    for (int r = 0; r < 5; r++) begin
      n = (r == 0) ? 1 : $urandom_range(1, 8);
      for (int k = 0; k < n; k++) mdl_codes[k] = 6'($urandom_range(0, 63));
      do_clear();
      write_codes(n);
      checks++; if (count !== 4'(n)) begin errors++; $display("FAIL rnd_count r=%0d got %0d want %0d", r, count, n); end
      play = 1'b1;
      for (int c = 0; c < 3 * pass_len(n, 1) + 2; c++) begin
        tick();
        checks++; if (seg !== exp_seg(c, n, 1)) begin errors++; $display("FAIL rnd_seg r=%0d c=%0d got %h want %h", r, c, seg, exp_seg(c, n, 1)); end
        checks++; if (done !== exp_done(c, n, 1)) begin errors++; $display("FAIL rnd_done r=%0d c=%0d got %b want %b", r, c, done, exp_done(c, n, 1)); end
        checks++; if (busy !== exp_busy(c, n, 1)) begin errors++; $display("FAIL rnd_busy r=%0d c=%0d got %b want %b", r, c, busy, exp_busy(c, n, 1)); end
        checks++; if (index !== exp_index(c, n, 1)) begin errors++; $display("FAIL rnd_index r=%0d c=%0d got %0d want %0d", r, c, index, exp_index(c, n, 1)); end
      end
      play = 1'b0;
      tick();
    end
  endtask

  task automatic test_invalid_code_no_gap();
    mdl_codes[0] = 6'd50;
    g_clear = 1'b1;
    tick();
    g_clear = 1'b0; g_wr_valid = 1'b1; g_wr_code = 6'd50;
    tick();
    g_wr_valid = 1'b0;
    checks++; if (g_count !== 4'd1) begin errors++; $display("FAIL g0_count got %0d want 1", g_count); end
    g_play = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      checks++; if (g_seg !== exp_seg(c, 1, 0)) begin errors++; $display("FAIL g0_seg c=%0d got %h want %h", c, g_seg, exp_seg(c, 1, 0)); end
      checks++; if (g_done !== exp_done(c, 1, 0)) begin errors++; $display("FAIL g0_done c=%0d got %b want %b", c, g_done, exp_done(c, 1, 0)); end
    end
    g_play = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    mdl_codes[0] = 6'd3; mdl_codes[1] = 6'd16; mdl_codes[2] = 6'd41;
    do_clear();
    write_codes(3);
    play = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (seg !== 8'h00 || busy !== 1'b0 || count !== 4'd0 || index !== 3'd0 || done !== 1'b0)
      begin errors++; $display("FAIL async_reset seg=%h busy=%b count=%0d index=%0d done=%b want all 0", seg, busy, count, index, done); end
    play = 1'b0;
    @(negedge clk_2);
    rst_n = 1'b1;
    tick();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL async_reset_wr_ready got %b want 1", wr_ready); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0; wr_valid = 1'b0; wr_code = 6'd0; play = 1'b0;
    g_clear = 1'b0; g_wr_valid = 1'b0; g_wr_code = 6'd0; g_play = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_abort();
    test_clear_priority();
    test_random_messages();
    test_invalid_code_no_gap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
